// File: rtl/data_rdbuf_pkg.sv
// Shared constants for the data read path: BRAM timing, word widths and
// the field layout of the input-shape configuration register.
package data_rdbuf_pkg;

    localparam int DEF_RD_LATENCY = 2;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_REG_WIDTH  = 32;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_PTR_WIDTH  = 3;

    localparam int INSHAPE_W_MSB  = 7;
    localparam int INSHAPE_W_LSB  = 0;

    typedef logic [INSHAPE_W_MSB-INSHAPE_W_LSB:0] row_w_t;

endpackage

// File: rtl/data_rdbuf_fifo.sv
// Show-ahead synchronous FIFO holding returned BRAM words; a write into a
// full FIFO without a simultaneous read is dropped.
module rdbuf_fifo
    import data_rdbuf_pkg::*;
#(
    parameter int DW    = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int PW    = DEF_PTR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          wr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_i,
    output logic [DW-1:0] rdata_o,
    output logic [PW:0]   count_o
);

    localparam logic [PW:0]   FULL_C  = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_wr_s, do_rd_s;

    always_comb begin
        do_rd_s  = rd_i & (count_q != '0);
        do_wr_s  = wr_i & ((count_q != FULL_C) | do_rd_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_rd_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is cleared on reset so the head word reads as zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (!clr_i && do_wr_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/data_rdbuf.sv
// Read-return buffer: tracks BRAM reads in flight, captures returned words,
// hands them to the PE array with row-end tagging and back-pressures the requester.
module data_rdbuf
    import data_rdbuf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int PTR_WIDTH  = DEF_PTR_WIDTH,
    parameter int REG_WIDTH  = DEF_REG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rden,
    input  logic [DATA_WIDTH-1:0] i_rddata,
    input  logic                  i_flush,
    input  logic [REG_WIDTH-1:0]  i_conf_inputshape,
    output logic                  o_stall,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_vld,
    output logic                  o_last,
    input  logic                  i_ready,
    output logic [REG_WIDTH-1:0]  dbg_rdbuf_count,
    output logic                  dbg_rdbuf_ovf
);

    localparam logic [PTR_WIDTH+1:0] DEPTH_SUM = (PTR_WIDTH+2)'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH:0]   FULL_C    = (PTR_WIDTH+1)'(FIFO_DEPTH);

    logic [RD_LATENCY-1:0]  pipe_q, pipe_d;
    logic [RD_LATENCY:0]    pipe_shift_s;
    logic                   push_s, pop_s;
    logic [PTR_WIDTH:0]     count_s, inflight_s;
    logic [PTR_WIDTH+1:0]   occ_sum_s;
    row_w_t                 row_w_s, row_w_m1_s, row_cnt_q, row_cnt_d;
    logic                   last_match_s;
    logic                   ovf_q, ovf_d;
    logic                   unused_shape_s;

    // Upper shape fields are consumed elsewhere in the datapath.
    assign unused_shape_s = ^i_conf_inputshape[REG_WIDTH-1:INSHAPE_W_MSB+1];

    assign push_s = pipe_q[RD_LATENCY-1];

    always_comb begin
        pipe_shift_s = {pipe_q, i_rden};
        if (i_flush) begin
            pipe_d = '0;
        end else begin
            pipe_d = pipe_shift_s[RD_LATENCY-1:0];
        end
        inflight_s = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_s = inflight_s + {{PTR_WIDTH{1'b0}}, pipe_q[i]};
        end
    end

    rdbuf_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .PW    (PTR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (i_flush),
        .wr_i    (push_s),
        .wdata_i (i_rddata),
        .rd_i    (pop_s),
        .rdata_o (o_data),
        .count_o (count_s)
    );

    // Stall counts reads already issued so every in-flight return has a slot.
    assign occ_sum_s = {1'b0, count_s} + {1'b0, inflight_s};
    assign o_stall   = (occ_sum_s >= DEPTH_SUM);
    assign o_vld     = (count_s != '0);
    assign pop_s     = o_vld & i_ready;

    always_comb begin
        row_w_s      = i_conf_inputshape[INSHAPE_W_MSB:INSHAPE_W_LSB];
        row_w_m1_s   = row_w_s - 8'd1;
        last_match_s = (row_w_s != 8'd0) && (row_cnt_q == row_w_m1_s);
        row_cnt_d    = row_cnt_q;
        if (i_flush || (row_w_s == 8'd0)) begin
            row_cnt_d = 8'd0;
        end else if (pop_s) begin
            if (last_match_s) begin
                row_cnt_d = 8'd0;
            end else begin
                row_cnt_d = row_cnt_q + 8'd1;
            end
        end else begin
            row_cnt_d = row_cnt_q;
        end
        if (push_s && !pop_s && !i_flush && (count_s == FULL_C)) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q    <= '0;
            row_cnt_q <= 8'd0;
            ovf_q     <= 1'b0;
        end else begin
            pipe_q    <= pipe_d;
            row_cnt_q <= row_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_last          = o_vld & last_match_s;
    assign dbg_rdbuf_count = {{(REG_WIDTH-PTR_WIDTH-1){1'b0}}, count_s};
    assign dbg_rdbuf_ovf   = ovf_q;

endmodule

// File: tb/tb_data_rdbuf.sv
// Directed bench for data_rdbuf with a two-cycle BRAM return model.
module tb_data_rdbuf;

    logic        clk, rst, i_rden, i_flush, i_ready;
    logic [31:0] i_rddata, i_conf_inputshape;
    logic        o_stall, o_vld, o_last, dbg_rdbuf_ovf;
    logic [31:0] o_data, dbg_rdbuf_count;

    int          n_checks, n_errors;
    logic [31:0] req_val;
    logic        bram_v1, bram_v2;
    logic [31:0] bram_d1, bram_d2;

    data_rdbuf dut (
        .clk               (clk),
        .rst               (rst),
        .i_rden            (i_rden),
        .i_rddata          (i_rddata),
        .i_flush           (i_flush),
        .i_conf_inputshape (i_conf_inputshape),
        .o_stall           (o_stall),
        .o_data            (o_data),
        .o_vld             (o_vld),
        .o_last            (o_last),
        .i_ready           (i_ready),
        .dbg_rdbuf_count   (dbg_rdbuf_count),
        .dbg_rdbuf_ovf     (dbg_rdbuf_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM model: data requested with i_rden appears two cycles later.
    always @(posedge clk) begin
        bram_v1 <= i_rden;
        bram_d1 <= req_val;
        bram_v2 <= bram_v1;
        bram_d2 <= bram_d1;
    end
    assign i_rddata = bram_v2 ? bram_d2 : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle: drive just after posedge, return at negedge for sampling.
    task automatic cyc(input logic rden, input logic [31:0] val);
        @(posedge clk);
        #1;
        i_rden  = rden;
        req_val = val;
        @(negedge clk);
    endtask

    // Issue reads only while the buffer is not stalling.
    task automatic fill_gated(input int ncyc, input logic [31:0] base, output int issued, output int stall_seen);
        issued     = 0;
        stall_seen = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            i_rden  = ~o_stall;
            req_val = base + 32'(issued);
            if (!o_stall) issued++;
            @(negedge clk);
            if (o_stall) stall_seen = 1;
        end
        i_rden = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"},   {31'b0, o_vld},   32'h0);
        chk({tag, "_last"},  {31'b0, o_last},  32'h0);
        chk({tag, "_stall"}, {31'b0, o_stall}, 32'h0);
        chk({tag, "_data"},  o_data,           32'h0);
        chk({tag, "_count"}, dbg_rdbuf_count,  32'h0);
        chk({tag, "_ovf"},   {31'b0, dbg_rdbuf_ovf}, 32'h0);
    endtask

    initial begin
        int issued, stall_seen, gaps, stall_hits, first_seen;
        logic [31:0] exp;
        n_checks = 0; n_errors = 0;
        rst = 1'b1; i_rden = 1'b0; req_val = 32'h0; i_flush = 1'b0;
        i_ready = 1'b0; i_conf_inputshape = 32'h0;
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);

        // Single read round trip.
        i_ready = 1'b1;
        cyc(1'b1, 32'hA5A5_0001); chk("single_c0_vld", {31'b0, o_vld}, 32'h0);
        cyc(1'b0, 32'h0);         chk("single_c1_vld", {31'b0, o_vld}, 32'h0);
        cyc(1'b0, 32'h0);         chk("single_c2_vld", {31'b0, o_vld}, 32'h0);
        cyc(1'b0, 32'h0);
        chk("single_c3_vld", {31'b0, o_vld}, 32'h1);
        chk("single_c3_data", o_data, 32'hA5A5_0001);
        chk("single_c3_count", dbg_rdbuf_count, 32'h1);
        cyc(1'b0, 32'h0);
        chk("single_c4_vld", {31'b0, o_vld}, 32'h0);
        chk("single_c4_count", dbg_rdbuf_count, 32'h0);

        // Backpressure: fill to full, then drain in order.
        i_ready = 1'b0;
        fill_gated(24, 32'h100, issued, stall_seen);
        repeat (3) cyc(1'b0, 32'h0);
        chk("bp_issued", 32'(issued), 32'd8);
        chk("bp_stall_seen", 32'(stall_seen), 32'd1);
        chk("bp_count", dbg_rdbuf_count, 32'd8);
        chk("bp_stall", {31'b0, o_stall}, 32'h1);
        chk("bp_ovf", {31'b0, dbg_rdbuf_ovf}, 32'h0);
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("bp_drain_vld", {31'b0, o_vld}, 32'h1);
            chk("bp_drain_data", o_data, 32'h100 + 32'(k));
            cyc(1'b0, 32'h0);
        end
        chk("bp_empty_vld", {31'b0, o_vld}, 32'h0);
        chk("bp_empty_count", dbg_rdbuf_count, 32'h0);

        // Streaming 1..100 with ready held high.
        exp = 32'd1; gaps = 0; stall_hits = 0; first_seen = 0;
        for (int c = 0; c < 110; c++) begin
            cyc(c < 100, 32'(c + 1));
            if (o_stall) stall_hits++;
            if (o_vld) begin
                chk("stream_data", o_data, exp);
                exp = exp + 32'd1;
                first_seen = 1;
            end else if (first_seen != 0 && exp <= 32'd100) begin
                gaps++;
            end
        end
        chk("stream_words", exp, 32'd101);
        chk("stream_gaps", 32'(gaps), 32'd0);
        chk("stream_stall", 32'(stall_hits), 32'd0);

        // Row tagging with W=5 over 12 words.
        i_conf_inputshape = 32'h0000_0005;
        exp = 32'd1;
        for (int c = 0; c < 20; c++) begin
            cyc(c < 12, 32'(c + 1));
            if (o_vld) begin
                chk("row_data", o_data, exp);
                chk("row_last", {31'b0, (exp % 32'd5) == 32'd0}, {31'b0, o_last});
                exp = exp + 32'd1;
            end
        end
        chk("row_words", exp, 32'd13);
        chk("row_cnt_end", {24'b0, dut.row_cnt_q}, 32'd2);
        i_conf_inputshape = 32'h0;

        // Flush with 4 buffered and 2 in flight.
        i_ready = 1'b0;
        for (int k = 0; k < 6; k++) cyc(1'b1, 32'h200 + 32'(k));
        cyc(1'b0, 32'h0);
        chk("flush_pre_count", dbg_rdbuf_count, 32'd4);
        i_flush = 1'b1;
        @(posedge clk); #1; i_flush = 1'b0;
        @(negedge clk);
        chk("flush_vld", {31'b0, o_vld}, 32'h0);
        chk("flush_count", dbg_rdbuf_count, 32'h0);
        repeat (3) cyc(1'b0, 32'h0);
        chk("flush_late_count", dbg_rdbuf_count, 32'h0);
        chk("flush_late_vld", {31'b0, o_vld}, 32'h0);

        // Async reset mid-burst; stale returns after release are ignored.
        for (int k = 0; k < 4; k++) cyc(1'b1, 32'h300 + 32'(k));
        chk("arst_pre_count", dbg_rdbuf_count, 32'd1);
        #2; rst = 1'b1; #1;
        chk_all_zero("arst");
        @(posedge clk); #1; i_rden = 1'b0;
        @(negedge clk); #2; rst = 1'b0;
        repeat (3) cyc(1'b0, 32'h0);
        chk("arst_stale_count", dbg_rdbuf_count, 32'h0);
        chk("arst_stale_vld", {31'b0, o_vld}, 32'h0);
        i_ready = 1'b1;
        cyc(1'b1, 32'hCAFE_0001);
        repeat (3) cyc(1'b0, 32'h0);
        chk("arst_rt_vld", {31'b0, o_vld}, 32'h1);
        chk("arst_rt_data", o_data, 32'hCAFE_0001);
        cyc(1'b0, 32'h0);
        chk("arst_rt_done", {31'b0, o_vld}, 32'h0);

        // Forced overflow: reads ignoring stall while full.
        i_ready = 1'b0;
        fill_gated(16, 32'h400, issued, stall_seen);
        repeat (3) cyc(1'b0, 32'h0);
        chk("ovf_pre_count", dbg_rdbuf_count, 32'd8);
        chk("ovf_pre_flag", {31'b0, dbg_rdbuf_ovf}, 32'h0);
        cyc(1'b1, 32'hDEAD_0000);
        cyc(1'b1, 32'hDEAD_0001);
        repeat (3) cyc(1'b0, 32'h0);
        chk("ovf_flag", {31'b0, dbg_rdbuf_ovf}, 32'h1);
        chk("ovf_count", dbg_rdbuf_count, 32'd8);
        repeat (3) cyc(1'b0, 32'h0);
        chk("ovf_sticky", {31'b0, dbg_rdbuf_ovf}, 32'h1);
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("ovf_drain_data", o_data, 32'h400 + 32'(k));
            cyc(1'b0, 32'h0);
        end
        chk("ovf_drain_empty", {31'b0, o_vld}, 32'h0);
        i_flush = 1'b1;
        @(posedge clk); #1; i_flush = 1'b0;
        @(negedge clk);
        chk("ovf_after_flush", {31'b0, dbg_rdbuf_ovf}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_rdbuf.md
Name: data_rdbuf

Overview:
- Read-return buffer directly downstream of the data read-request stage.
- Tracks BRAM reads in flight using the request stage's read-enable and a fixed BRAM read latency, then captures the returned words into a small FIFO.
- Presents the words to the PE array with a valid/ready handshake and tags the last word of each input row.
- Drives the stall input of the request stage, so the FIFO can never overflow.

Parameters:
- DATA_WIDTH, 32, width of a BRAM data word.
- RD_LATENCY, 2, BRAM read latency in cycles (1..4): rden at cycle t returns data at t+RD_LATENCY.
- FIFO_DEPTH, 8, FIFO entries (power of 2, at least RD_LATENCY+1).
- PTR_WIDTH, 3, log2(FIFO_DEPTH).
- REG_WIDTH, 32, configuration/debug register width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- i_rden  in  1  read-enable issued to BRAM by the request stage.
- i_rddata  in  DATA_WIDTH  BRAM read data.
- i_flush  in  1  synchronous clear of the FIFO, the in-flight pipe and the row counter.
- i_conf_inputshape  in  REG_WIDTH  bits [7:0] give the row width W in words.
- o_stall  out  1  goes to the stall input of the request stage.
- o_data  out  DATA_WIDTH  head-of-FIFO word.
- o_vld  out  1  o_data is valid.
- o_last  out  1  o_data is the last word of a row; qualified by o_vld.
- i_ready  in  1  PE array accepts the word.
- dbg_rdbuf_count  out  REG_WIDTH  zero-extended FIFO occupancy.
- dbg_rdbuf_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (async, rst=1): FIFO pointers, count, in-flight pipe, row counter and ovf flag all go to 0. Outputs: o_vld=0, o_last=0, o_stall=0, o_data=0, dbg_rdbuf_count=0, dbg_rdbuf_ovf=0.
- Reset mid-operation drops all in-flight data. BRAM returns arriving after rst deasserts are ignored because the pipe is already cleared.
- In-flight pipe:
  - RD_LATENCY-bit shift register; bit 0 is loaded with i_rden each cycle.
  - push = bit[RD_LATENCY-1]. On push, i_rddata is written to the FIFO that same cycle.
  - inflight = popcount of the pipe.
- Pop: pop = o_vld & i_ready.
- o_vld = (count != 0). o_data is the head entry, combinational from FIFO storage and read pointer. First-word latency is RD_LATENCY+1 cycles from i_rden.
- Count update: push only gives +1; pop only gives -1; push and pop together leave count unchanged. Push and pop are legal together at any occupancy, including full.
- Flow control:
  - o_stall = (count + inflight) >= FIFO_DEPTH.
  - It is computed from registered state only, with no combinational path from any input.
  - A read granted at count+inflight = FIFO_DEPTH-1 raises o_stall on the next cycle, so occupancy never exceeds FIFO_DEPTH.
- Overflow: push while count==FIFO_DEPTH and no pop.
  - The write is dropped and dbg_rdbuf_ovf sets and stays set until rst.
  - Pointers are unchanged.
- Row tagging:
  - row_cnt (8 bit) increments on pop.
  - o_last = o_vld & (row_cnt == W-1).
  - A pop with o_last wraps row_cnt to 0.
  - W==0: o_last held 0 and row_cnt held 0.
  - W is sampled combinationally; software changes it only while idle.
- i_flush (synchronous, priority over push/pop):
  - Next cycle: count=0, pointers=0, pipe=0, row_cnt=0, o_vld=0.
  - Does not clear dbg_rdbuf_ovf.
- Width rules: count and inflight are PTR_WIDTH+1 bits; the sum is compared in PTR_WIDTH+2 bits. Pointers wrap naturally modulo FIFO_DEPTH.

Decomposition:
- Shared package holds:
  - RD_LATENCY default (BRAM latency, common to the request stage).
  - DATA_WIDTH and REG_WIDTH defaults.
  - INSHAPE_W_MSB/LSB = 7/0 field constants for i_conf_inputshape.
- Sub-module: rdbuf_fifo, a synchronous FIFO.
  - Ports: clk, rst, wr, wdata, rd, rdata, count.
  - Show-ahead read; holds storage, pointers and count.
- The top level holds the in-flight pipe, stall logic, row counter and debug outputs.

Test Plan:
- Single read: i_rden pulse at cycle 0, i_rddata=0xA5A5_0001 at cycle 2, i_ready=1 -> o_vld=1 with o_data=0xA5A5_0001 at cycle 3; pops that cycle; count returns to 0.
- Backpressure: i_ready=0, i_rden=1 whenever o_stall=0 -> o_stall rises when count+inflight=8; count settles at 8; dbg_rdbuf_ovf stays 0; after i_ready=1, the 8 words drain in order.
- Streaming: i_ready=1, continuous i_rden, data sequence 1..100 -> o_data 1..100 in order with no gaps after the first valid; o_stall never asserted.
- Row tag: W=5, 12 words popped -> o_last on words 5 and 10 only; row_cnt=2 at the end.
- Flush: 4 words buffered and 2 in flight, i_flush=1 for one cycle -> o_vld=0 next cycle; the in-flight returns are discarded; count=0.
- Async reset: rst asserted mid-burst between clock edges -> all outputs 0 immediately; after release, the first new rden round-trips correctly.
- Forced overflow (i_rden driven while o_stall=1, count=8, no pop) -> dbg_rdbuf_ovf=1 and sticky; count stays 8.
